// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//  Shared definitions for the bit-serial adder controller.
//  Contents:
//    STATE_W     width of the controller state register
//    state_t     controller state encoding (IDLE / SHIFT / DONE)
//    S_ILLEGAL   the one unused code; the FSM steers it back to IDLE
//    WIDTH_MIN/WIDTH_MAX  legal operand width range
//    state_is_busy()      busy decode shared by RTL and any bound checker
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int STATE_W   = 2;
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Unreachable in normal operation; only an upset could land here.
   localparam logic [STATE_W-1:0] S_ILLEGAL = 2'd3;

   // busy covers the whole time an operation owns the datapath,
   // including the single DONE cycle where the result is presented.
   function automatic logic state_is_busy(input state_t s);
      return (s == S_SHIFT) || (s == S_DONE);
   endfunction

endpackage : serial_adder_pkg

// File: rtl/full_adder_ha.sv
// ---------------------------------------------------------------------------
// full_adder_ha
//  One-bit full adder built from two half adders. This is the only adder
//  in the serial add path; the controller reuses it once per bit.
//  Ports:
//    a, b    in   operand bits
//    cin     in   carry in
//    sum     out  a ^ b ^ cin
//    carry   out  majority(a, b, cin)
// ---------------------------------------------------------------------------
module full_adder_ha (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   logic ha0_sum;
   logic ha0_carry;
   logic ha1_sum;
   logic ha1_carry;

   // First half adder: the two operand bits.
   assign ha0_sum   = a ^ b;
   assign ha0_carry = a & b;

   // Second half adder: partial sum with the incoming carry.
   assign ha1_sum   = ha0_sum ^ cin;
   assign ha1_carry = ha0_sum & cin;

   // The two half-adder carries can never both be 1, so OR is exact.
   assign sum   = ha1_sum;
   assign carry = ha0_carry | ha1_carry;

endmodule : full_adder_ha

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//  Bit-serial WIDTH-bit adder. A single full_adder_ha cell is sequenced over
//  WIDTH cycles, LSB first, to form a_in + b_in + cin_in.
//
//  Handshake: start is a request that is only looked at while IDLE. When it
//  is seen high at a rising edge in IDLE the operands are captured on that
//  same edge and the request is consumed; start seen in SHIFT or DONE is
//  dropped, as are the operand inputs. done is a one-cycle pulse and the
//  result on sum_out/cout_out is valid from that cycle until the next done.
//  There is no back-pressure on the result side.
//
//  Ports:
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    start      in   operation request (sampled in IDLE only)
//    a_in       in   operand A  [WIDTH]
//    b_in       in   operand B  [WIDTH]
//    cin_in     in   carry-in
//    busy       out  high in SHIFT and DONE
//    done       out  one-cycle completion pulse
//    sum_out    out  registered sum [WIDTH]
//    cout_out   out  registered carry-out
//    state_dbg  out  raw controller state register, for observation only
//
//  Timing: start sampled at edge E0, WIDTH shift edges follow, done is high
//  in the cycle after edge E0+WIDTH. Minimum start-to-start spacing is
//  WIDTH+2 cycles. WIDTH must lie in 2..32.
// ---------------------------------------------------------------------------
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   input  logic               cin_in,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   sum_out,
   output logic               cout_out,
   output logic [STATE_W-1:0] state_dbg
);

   localparam int              CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   // Only WIDTH-1 bits are stored: on the last shift the cell's sum bit is
   // concatenated on top to form the full result directly into sum_out.
   logic [WIDTH-2:0]   s_sr;
   logic               c_q;
   logic [CW-1:0]      count;

   logic               fa_sum;
   logic               fa_carry;
   logic [WIDTH-1:0]   s_next;

   // -------------------------------------------------------------------------
   // The single arithmetic cell.
   // -------------------------------------------------------------------------
   full_adder_ha u_fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .cin   (c_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // Sum register after this edge's shift: new bit enters at the MSB so the
   // LSB computed first ends up at bit 0 after WIDTH shifts.
   assign s_next = {fa_sum, s_sr};

   // -------------------------------------------------------------------------
   // Controller, counter and shift registers.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         s_sr     <= '0;
         c_q      <= 1'b0;
         count    <= '0;
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sr  <= a_in;
                  b_sr  <= b_in;
                  c_q   <= cin_in;
                  s_sr  <= '0;
                  count <= '0;
                  state <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               s_sr <= s_next[WIDTH-1:1];
               a_sr <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr <= {1'b0, b_sr[WIDTH-1:1]};
               c_q  <= fa_carry;
               if (count == LAST) begin
                  // Final bit: publish the result. count is returned to 0
                  // rather than incremented so it never reaches WIDTH.
                  sum_out  <= s_next;
                  cout_out <= fa_carry;
                  count    <= '0;
                  state    <= S_DONE;
               end else begin
                  count <= count + 1'b1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               // S_ILLEGAL: abandon whatever was in flight, no done.
               state <= S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Status outputs are pure decodes of the state flop: no path from start.
   // -------------------------------------------------------------------------
   assign busy      = state_is_busy(state);
   assign done      = (state == S_DONE);
   assign state_dbg = state;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//  Bench for serial_adder_ctrl. One WIDTH=8 instance carries the directed
//  and random scenarios, a WIDTH=4 instance is swept exhaustively.
//  Expected {cout,sum} values are pushed when an operation is started and
//  popped when the matching done pulse is observed.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

   // ------------------------------------------------------------ clock/reset
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ WIDTH=8 DUT
   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       cin8;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;
   logic [1:0] st8;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start8),
      .a_in      (a8),
      .b_in      (b8),
      .cin_in    (cin8),
      .busy      (busy8),
      .done      (done8),
      .sum_out   (sum8),
      .cout_out  (cout8),
      .state_dbg (st8)
   );

   // ------------------------------------------------------------ WIDTH=4 DUT
   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       cin4;
   logic       busy4;
   logic       done4;
   logic [3:0] sum4;
   logic       cout4;
   logic [1:0] st4;

   serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start4),
      .a_in      (a4),
      .b_in      (b4),
      .cin_in    (cin4),
      .busy      (busy4),
      .done      (done4),
      .sum_out   (sum4),
      .cout_out  (cout4),
      .state_dbg (st4)
   );

   // ------------------------------------------------------------ scoreboard
   logic [8:0] exp_q8[$];
   logic [4:0] exp_q4[$];
   int vectors;
   int miscompares;

   // ------------------------------------------------------------ driver tasks
   // Start one WIDTH=8 operation: start high for one cycle. Returns at the
   // first falling edge after the accepting rising edge.
   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
      @(negedge clk);
      a8     = a;
      b8     = b;
      cin8   = c;
      start8 = 1'b1;
      exp_q8.push_back(9'(a) + 9'(b) + 9'(c));
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
      @(negedge clk);
      a4     = a;
      b4     = b;
      cin4   = c;
      start4 = 1'b1;
      exp_q4.push_back(5'(a) + 5'(b) + 5'(c));
      @(negedge clk);
      start4 = 1'b0;
   endtask

   // Bounded wait for done, counting falling edges from the current one
   // (which counts as 1) and how many of them saw busy high.
   task automatic wait_done(input int which, output int cyc, output int bcyc, output bit ok);
      cyc  = 1;
      bcyc = 0;
      ok   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if ((which == 0) ? busy8 : busy4) bcyc++;
         if ((which == 0) ? done8 : done4) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset;
      rst_n  = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      #1;
      vectors++;
      if ({busy8, done8, cout8, sum8, st8} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_w8: busy=%b done=%b cout=%b sum=%h st=%0d, want all 0",
                  busy8, done8, cout8, sum8, st8);
      end
      vectors++;
      if ({busy4, done4, cout4, sum4, st4} !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_w4: busy=%b done=%b cout=%b sum=%h st=%0d, want all 0",
                  busy4, done4, cout4, sum4, st4);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_no_start: busy=%b done=%b, want 0 0", busy8, done8);
      end
   endtask

   task automatic test_basic;
      int cyc, bc; bit ok;
      logic [8:0] e;
      drive8(8'h5A, 8'h3C, 1'b0);
      wait_done(0, cyc, bc, ok);
      e = exp_q8.pop_front();
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL basic_timeout: no done within 40 cycles");
      end else begin
         vectors++;
         if (cyc !== 9) begin
            miscompares++;
            $display("FAIL basic_latency: done after %0d cycles, want 9", cyc);
         end
         vectors++;
         if (bc !== 9) begin
            miscompares++;
            $display("FAIL basic_busy_len: busy %0d cycles, want 9", bc);
         end
         vectors++;
         if ({cout8, sum8} !== e) begin
            miscompares++;
            $display("FAIL basic_result: got %h, want %h", {cout8, sum8}, e);
         end
      end
      @(negedge clk);
      vectors++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h96 || cout8 !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_after: done=%b busy=%b sum=%h cout=%b, want 0 0 96 0",
                  done8, busy8, sum8, cout8);
      end
   endtask

   task automatic test_wrap;
      int cyc, bc; bit ok;
      logic [8:0] e;
      logic [24:0] tbl [3];
      tbl[0] = {8'hFF, 8'h01, 1'b0, 8'h00};
      tbl[1] = {8'hFF, 8'hFF, 1'b1, 8'h00};
      tbl[2] = {8'h00, 8'h00, 1'b1, 8'h00};
      for (int i = 0; i < 3; i++) begin
         drive8(tbl[i][24:17], tbl[i][16:9], tbl[i][8]);
         wait_done(0, cyc, bc, ok);
         e = exp_q8.pop_front();
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL wrap_timeout[%0d]: no done", i);
         end else if ({cout8, sum8} !== e) begin
            miscompares++;
            $display("FAIL wrap_result[%0d]: got %h, want %h", i, {cout8, sum8}, e);
         end
      end
   endtask

   task automatic test_busy_ignore;
      int cyc, bc; bit ok;
      logic [8:0] e;
      bit extra;
      drive8(8'h5A, 8'h3C, 1'b0);
      repeat (2) @(negedge clk);
      a8 = 8'h11; b8 = 8'h77; cin8 = 1'b1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done(0, cyc, bc, ok);
      e = exp_q8.pop_front();
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL ignore_timeout: no done");
      end else if ({cout8, sum8} !== e) begin
         miscompares++;
         $display("FAIL ignore_result: got %h, want %h", {cout8, sum8}, e);
      end
      extra = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 !== 1'b0 || busy8 !== 1'b0) extra = 1'b1;
      end
      vectors++;
      if (extra) begin
         miscompares++;
         $display("FAIL ignore_no_second_op: busy/done seen after ignored start, want none");
      end

      // start held high across two operations
      @(negedge clk);
      a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
      exp_q8.push_back(9'h0A5 + 9'h05A + 9'd1);
      @(negedge clk);
      wait_done(0, cyc, bc, ok);
      e = exp_q8.pop_front();
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL held1_timeout: no done");
      end else if ({cout8, sum8} !== e) begin
         miscompares++;
         $display("FAIL held1_result: got %h, want %h", {cout8, sum8}, e);
      end
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
      exp_q8.push_back(9'h080 + 9'h080);
      @(negedge clk);
      vectors++;
      if (busy8 !== 1'b0) begin
         miscompares++;
         $display("FAIL held_idle_gap: busy=%b in cycle after done, want 0", busy8);
      end
      wait_done(0, cyc, bc, ok);
      start8 = 1'b0;
      e = exp_q8.pop_front();
      vectors++;
      if (!ok || cyc !== 10) begin
         miscompares++;
         $display("FAIL held_spacing: done-to-done %0d cycles (ok=%b), want 10", cyc, ok);
      end
      vectors++;
      if ({cout8, sum8} !== e) begin
         miscompares++;
         $display("FAIL held2_result: got %h, want %h", {cout8, sum8}, e);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (busy8 !== 1'b0) begin
         miscompares++;
         $display("FAIL held_release: busy=%b after start dropped, want 0", busy8);
      end
   endtask

   task automatic test_reset_abort;
      int cyc, bc; bit ok;
      logic [8:0] e;
      bit seen;
      drive8(8'hFF, 8'h0F, 1'b0);
      wait_done(0, cyc, bc, ok);
      e = exp_q8.pop_front();
      vectors++;
      if (!ok || {cout8, sum8} !== e) begin
         miscompares++;
         $display("FAIL pre_abort_result: got %h (ok=%b), want %h", {cout8, sum8}, ok, e);
      end
      drive8(8'h33, 8'h44, 1'b0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      // aborted operation will never complete
      void'(exp_q8.pop_back());
      #1;
      vectors++;
      if ({busy8, done8, cout8, sum8, st8} !== 13'd0) begin
         miscompares++;
         $display("FAIL abort_async: busy=%b done=%b cout=%b sum=%h st=%0d, want all 0",
                  busy8, done8, cout8, sum8, st8);
      end
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 !== 1'b0) seen = 1'b1;
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL abort_no_done: done/busy seen after abort, want none");
      end
      drive8(8'h20, 8'h22, 1'b0);
      wait_done(0, cyc, bc, ok);
      e = exp_q8.pop_front();
      vectors++;
      if (!ok || cyc !== 9 || {cout8, sum8} !== e) begin
         miscompares++;
         $display("FAIL post_abort: got %h after %0d cycles (ok=%b), want %h after 9",
                  {cout8, sum8}, cyc, ok, e);
      end
   endtask

   task automatic test_exhaustive_w4;
      int cyc, bc; bit ok;
      logic [4:0] e;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               drive4(4'(ia), 4'(ib), 1'(ic));
               wait_done(1, cyc, bc, ok);
               e = exp_q4.pop_front();
               vectors++;
               if (!ok || cyc !== 5 || {cout4, sum4} !== e) begin
                  miscompares++;
                  $display("FAIL w4_exh a=%h b=%h c=%0d: got %h after %0d cycles (ok=%b), want %h after 5",
                           ia, ib, ic, {cout4, sum4}, cyc, ok, e);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int cyc, bc; bit ok;
      logic [8:0] e;
      for (int i = 0; i < 30; i++) begin
         drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
         wait_done(0, cyc, bc, ok);
         e = exp_q8.pop_front();
         vectors++;
         if (!ok || {cout8, sum8} !== e) begin
            miscompares++;
            $display("FAIL rand[%0d]: got %h (ok=%b), want %h", i, {cout8, sum8}, ok, e);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   // ------------------------------------------------------------ sequence + report
   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_basic();
      test_wrap();
      test_busy_ignore();
      test_reset_abort();
      test_exhaustive_w4();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_serial_adder_ctrl
